// File: rtl/i2c_responder.sv
// i2c_responder: I2C target that matches a 7-bit address and moves bytes to/from local logic.
module i2c_responder #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h52,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw,
  output logic       busy,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE} state_t;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic scl_s, sda_s, scl_r, scl_f, start, stop;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, tx_load_q, tx_load_d, rw_q, rw_d, busy_q, busy_d, sda_q, sda_d;
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign scl_r = scl_s & ~scl_prev_q;
  assign scl_f = ~scl_s & scl_prev_q;
  assign start = scl_s & sda_prev_q & ~sda_s;
  assign stop  = scl_s & ~sda_prev_q & sda_s;
  assign sda_out  = sda_q;
  assign tx_load  = tx_load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rw       = rw_q;
  assign busy     = busy_q;
  assign state    = state_q;
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], sclk};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    sda_d      = sda_q;
    // Bus conditions outrank any scl edge seen in the same clk.
    if (stop) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, RX: begin
          if (scl_r) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_f && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == RX) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_d      = 1'b0;
              state_d    = RX_ACK;
            end else if (shift_q[7:1] == SLAVE_ADDRESS) begin
              sda_d   = 1'b0;
              rw_d    = shift_q[0];
              busy_d  = 1'b1;
              state_d = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK, TX_ACK: begin
          if (state_q == TX_ACK && scl_r) begin
            // cnt cleared marks a master ACK; NACK drops out immediately.
            cnt_d   = sda_s ? cnt_q : 4'd0;
            busy_d  = sda_s ? 1'b0 : busy_q;
            state_d = sda_s ? IGNORE : TX_ACK;
          end else if (scl_f && (state_q == ADDR_ACK || cnt_q == 4'd0)) begin
            if (state_q == ADDR_ACK && !rw_q) begin
              sda_d   = 1'b1;
              cnt_d   = 4'd0;
              state_d = RX;
            end else begin
              tx_load_d  = 1'b1;
              sda_d      = tx_data[7];
              tx_shift_d = {tx_data[6:0], 1'b1};
              cnt_d      = 4'd1;
              state_d    = TX;
            end
          end
        end
        RX_ACK: begin
          if (scl_f) begin
            sda_d   = 1'b1;
            cnt_d   = 4'd0;
            state_d = RX;
          end
        end
        TX: begin
          if (scl_f) begin
            sda_d      = (cnt_q == 4'd8) ? 1'b1 : tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b1};
            cnt_d      = cnt_q + 4'd1;
            state_d    = (cnt_q == 4'd8) ? TX_ACK : TX;
          end
        end
        IGNORE: sda_d = 1'b1;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      tx_shift_q <= 8'hff;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      sda_q      <= sda_d;
    end
  end
endmodule

// File: doc/i2c_responder.md
Name: i2c_responder

Overview:
- I2C target (slave) responder: the other end of the bus from the team's I2C master.
- Oversamples `sclk`/`sda_in` on the internal `clk` and detects START/STOP.
- Matches a 7-bit address, ACKs, then receives bytes (master write) or transmits bytes (master read).
- Exposes a simple byte-level interface to local logic.

Parameters:
- SLAVE_ADDRESS, 7'h52, 7-bit bus address this block answers to.
- SYNC_STAGES, 2, synchronizer flops on `sclk` and `sda_in` (minimum 2).

Ports:
- clk       input   1  internal clock; all state on posedge.
- rst       input   1  asynchronous, active-low reset.
- sclk      input   1  serial clock from master.
- sda_in    input   1  serial data bus, sensed.
- sda_out   output  1  serial data drive; 1 = release (pulled high), 0 = pull low.
- tx_data   input   8  byte returned on next master-read byte; sampled at load point.
- tx_load   output  1  1-clk pulse when `tx_data` is captured.
- rx_data   output  8  last byte received from master.
- rx_valid  output  1  1-clk pulse when `rx_data` updates.
- rw        output  1  R/W bit of current transfer; 1 = master read, 0 = master write.
- busy      output  1  high from addressed ACK until STOP/START/NACK-release.
- state     output  3  current FSM state encoding.

Behaviour:
- Reset (`rst` = 0, async): `sda_out` = 1, `rx_data` = 8'h00, `rx_valid` = 0, `tx_load` = 0, `rw` = 0, `busy` = 0, `state` = IDLE, bit counter = 0. Synchronizers are preset to 1.
- Inputs pass through SYNC_STAGES flops. Rising/falling edges of synchronized `sclk` (`scl_r`, `scl_f`) come from comparison with the previous sample.
- Bus conditions:
  - START: synced sda falls while synced sclk high.
  - STOP: synced sda rises while synced sclk high.
- Framing and timing:
  - Bytes are MSB first.
  - Data is sampled on `scl_r`; `sda_out` changes only on `scl_f` (one clk after the detected edge is acceptable).
- States: IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, IGNORE=7.
- IDLE: on START -> ADDR, counter = 0.
- ADDR: shift 8 bits (7 address + R/W) on `scl_r`. On the `scl_f` following bit 8:
  - Match: drive `sda_out` = 0, latch `rw`, set `busy`, -> ADDR_ACK.
  - Mismatch: -> IGNORE, `sda_out` stays 1.
- ADDR_ACK: hold `sda_out` low through the ACK clock. On the next `scl_f`:
  - `rw` = 0: release `sda_out`, -> RX.
  - `rw` = 1: capture `tx_data`, pulse `tx_load`, drive MSB, -> TX.
- RX: shift 8 bits on `scl_r`. On the `scl_f` after bit 8:
  - `rx_data` <= shift register, pulse `rx_valid` that same clk.
  - Drive ACK (`sda_out` = 0), -> RX_ACK.
- RX_ACK: on next `scl_f`, release `sda_out`, -> RX (counter = 0).
- TX: present bits MSB..LSB, changing on each `scl_f`. After bit 8's `scl_f`, release `sda_out`, -> TX_ACK.
- TX_ACK: sample master ACK on `scl_r`.
  - ACK (0): on the following `scl_f`, capture next `tx_data`, pulse `tx_load`, drive MSB, -> TX.
  - NACK (1): keep released, clear `busy`, -> IGNORE.
- IGNORE: `sda_out` = 1; wait for STOP or START.
- Global overrides, with priority over all state logic:
  - STOP in any state: -> IDLE, `sda_out` = 1, `busy` = 0.
  - START in any state (repeated START): -> ADDR, counter = 0, `sda_out` = 1, `busy` = 0.
- Simultaneous events:
  - START/STOP take precedence over any `scl` edge detected in the same clk.
  - `rx_valid` and `tx_load` never assert in the same clk.
- Partial bytes aborted by START/STOP are discarded; `rx_data` keeps its old value.
- Reset mid-transfer releases the bus immediately (async). The next valid START is still decoded.
- Timing requirement: `clk` ≥ 8× `sclk` frequency so every `sclk` phase spans ≥ 4 clk. Behaviour below that ratio is undefined.

Test Plan:
- Reset: assert `rst` = 0 mid-ADDR -> `sda_out` = 1, `state` = 0, `busy` = 0 within the same clk; release, then START + 0xA4 (addr 0x52, W) -> ACK low.
- Write: START, 0xA4, data 0x3C, 0xC3, STOP -> ACK after each byte; `rx_valid` pulses twice, `rx_data` = 0x3C then 0xC3; `state` returns 0 after STOP.
- Read: START, 0xA5, `tx_data` = 0x96 then 0x5A, master ACKs byte 1 and NACKs byte 2 -> bus bits 10010110 then 01011010; `tx_load` pulses twice; IGNORE after NACK, then IDLE on STOP.
- Address miss: START, 0x20 (addr 0x10) -> `sda_out` stays 1 for all 9 clocks; `state` = 7; no `rx_valid`/`tx_load`.
- Repeated START: START, 0xA4, data 0x11, repeated START, 0xA5, read `tx_data` = 0xF0 with NACK -> `rx_data` = 0x11, `rw` flips to 1, 0xF0 shifted out.
- Abort: STOP after 4 data bits of a write -> no `rx_valid`; `rx_data` unchanged; `state` = 0.
